spi_reg_bank: RTL



---
 rtl/spi_reg_bank_if.sv | 19 +
 rtl/spi_reg_bank.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between an external master and the register bank.
// The master drives clock, select and data in; the slave returns data out and its pad enable.
interface spi_reg_bank_if;
    logic sclk;
    logic ncs;
    logic sdi;
    logic sdo;
    logic sdo_oe;

    modport master (
        output sclk, ncs, sdi,
        input  sdo, sdo_oe
    );

    modport slave (
        input  sclk, ncs, sdi,
        output sdo, sdo_oe
    );
endinterface

// File: rtl/spi_reg_bank.sv
// Parametrised SPI-slave register bank with write commit strobe and sdo readback.
// Optional read-only error status register at address NUM_REGS: SPI_REG_BANK_STATUS_EN.
module spi_reg_bank #(
    parameter int NUM_REGS    = 8,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    spi_reg_bank_if.slave              spi,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr
);
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [ADDR_W:0] NREG = (ADDR_W + 1)'(NUM_REGS);

    logic [SYNC_STAGES-1:0] sclk_sy, ncs_sy, sdi_sy;
    logic                   sclk_s, ncs_s, sdi_s;
    logic                   sclk_q, ncs_q;
    logic                   sclk_rise, sclk_fall, frame_end;

    logic [CNT_W-1:0]       bit_cnt;
    logic [FRAME_W-1:0]     rx_shift, rx_nxt;
    logic [DATA_W-1:0]      tx_shift, rd_data;
    logic [DATA_W-1:0]      regs [NUM_REGS];

    logic                   f_rw, full, in_range, commit, load;
    logic [ADDR_W-1:0]      f_addr, ld_addr;
    logic [DATA_W-1:0]      f_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sy <= '0;
            ncs_sy  <= '1;
            sdi_sy  <= '0;
            sclk_q  <= 1'b0;
            ncs_q   <= 1'b1;
        end else begin
            sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], spi.sclk};
            ncs_sy  <= {ncs_sy[SYNC_STAGES-2:0], spi.ncs};
            sdi_sy  <= {sdi_sy[SYNC_STAGES-2:0], spi.sdi};
            sclk_q  <= sclk_s;
            ncs_q   <= ncs_s;
        end
    end

    assign sclk_s    = sclk_sy[SYNC_STAGES-1];
    assign ncs_s     = ncs_sy[SYNC_STAGES-1];
    assign sdi_s     = sdi_sy[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign frame_end = ncs_s & ~ncs_q;

    assign rx_nxt   = {rx_shift[FRAME_W-2:0], sdi_s};
    assign f_rw     = rx_shift[FRAME_W-1];
    assign f_addr   = rx_shift[FRAME_W-2 -: ADDR_W];
    assign f_data   = rx_shift[DATA_W-1:0];
    assign full     = (bit_cnt == CNT_W'(FRAME_W));
    assign in_range = ({1'b0, f_addr} < NREG);
    assign commit   = frame_end & full & f_rw & in_range;

    // Address is complete on this rise; the new bit is its LSB.
    assign ld_addr = rx_nxt[ADDR_W-1:0];
    assign load    = sclk_rise & ~ncs_s & ~rx_nxt[ADDR_W] &
                     (bit_cnt == CNT_W'(ADDR_W));

`ifdef SPI_REG_BANK_STATUS_EN
    logic [DATA_W-2:0] err_cnt;
    logic              last_err;
    logic              err, frame_done;

    assign frame_done = frame_end & (bit_cnt != '0);
    assign err = frame_done &
                 (~full | (f_rw & ~in_range));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt  <= '0;
            last_err <= 1'b0;
        end else if (frame_done) begin
            last_err <= err;
            if (err && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (ld_addr == ADDR_W'(i))
                rd_data = regs[i];
`ifdef SPI_REG_BANK_STATUS_EN
        if ({1'b0, ld_addr} == NREG)
            rd_data = {err_cnt, last_err};
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
        end else if (ncs_s) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
        end else begin
            if (sclk_rise && !full) begin
                rx_shift <= rx_nxt;
                bit_cnt  <= bit_cnt + 1'b1;
            end
            // The fall right after the load keeps the MSB for the first data rise.
            if (load)
                tx_shift <= rd_data;
            else if (sclk_fall && bit_cnt > CNT_W'(ADDR_W + 1))
                tx_shift <= tx_shift << 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            wr_strobe <= commit;
            if (commit) begin
                wr_addr <= f_addr;
                for (int i = 0; i < NUM_REGS; i++)
                    if (f_addr == ADDR_W'(i))
                        regs[i] <= f_data;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign regs_out[g*DATA_W +: DATA_W] = regs[g];
    end

    assign spi.sdo    = tx_shift[DATA_W-1] & ~ncs_s;
    assign spi.sdo_oe = ~ncs_s;
endmodule
